// File: rtl/cache_pkg.sv
// Shared fetch command and fill state encodings for the cache read path.
// Used by the read controller, the fill responder and its bench.
package cache_pkg;

  typedef enum logic [1:0] {
    FETCH_NOP  = 2'b00,
    FETCH_LINE = 2'b01,
    FETCH_WORD = 2'b10,
    FETCH_RSVD = 2'b11
  } fetch_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FLUSH,
    DONE
  } fill_state_e;

  function automatic logic cmd_is_legal(input logic [1:0] cmd);
    return (cmd == FETCH_LINE) || (cmd == FETCH_WORD);
  endfunction

endpackage

// File: rtl/fill_addr_gen.sv
// Fill address generator: derives base address, word count and starting word index
// from a granted fetch, then steps the backing-memory read address per accepted request.
module fill_addr_gen
  import cache_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int list_width = 32,
  localparam int byte_w = $clog2(data_width / 8),
  localparam int idx_w  = $clog2(list_width),
  localparam int cnt_w  = idx_w + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [1:0]            cmd,
  input  logic [addr_width-1:0] addr,
  output logic [addr_width-1:0] rd_addr,
  output logic [cnt_w-1:0]      nwords,
  output logic [idx_w-1:0]      start_idx,
  output logic                  last_issue
);

  localparam logic [addr_width-1:0] word_keep = {addr_width{1'b1}} << byte_w;
  localparam logic [addr_width-1:0] line_keep = {addr_width{1'b1}} << (byte_w + idx_w);
  localparam logic [addr_width-1:0] stride    = addr_width'(data_width / 8);

  logic [addr_width-1:0] base_c;
  logic [cnt_w-1:0]      nwords_c;
  logic [idx_w-1:0]      start_c;
  logic [cnt_w-1:0]      issue_cnt;

  always_comb begin
    base_c   = addr & word_keep;
    nwords_c = cnt_w'(1);
    start_c  = addr[byte_w +: idx_w];
    if (cmd == FETCH_LINE) begin
      base_c   = addr & line_keep;
      nwords_c = cnt_w'(list_width);
      start_c  = '0;
    end
  end

  // rd_addr always equals base + issue_cnt * stride while issuing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      issue_cnt <= '0;
      nwords    <= '0;
      start_idx <= '0;
    end else if (load) begin
      rd_addr   <= base_c;
      issue_cnt <= '0;
      nwords    <= nwords_c;
      start_idx <= start_c;
    end else if (advance) begin
      rd_addr   <= rd_addr + stride;
      issue_cnt <= issue_cnt + 1'b1;
    end
  end

  assign last_issue = (issue_cnt == nwords - 1'b1);

endmodule

// File: rtl/fill_ctrl.sv
// Line-fill responder: grants one fetch at a time, reads the line or word from
// backing memory and writes it into the line-buffer slot chosen by the fetch tag.
module fill_ctrl
  import cache_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32,
  localparam int tag_w = $clog2(list_depth),
  localparam int idx_w = $clog2(list_width),
  localparam int cnt_w = idx_w + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_req,
  input  logic [1:0]             fetch_cmd,
  input  logic [tag_w-1:0]       fetch_tag,
  input  logic [addr_width-1:0]  fetch_addr,
  output logic                   fetch_gnt,
  output logic                   fetch_done,
  output logic                   ext_rd_valid,
  input  logic                   ext_rd_ready,
  output logic [addr_width-1:0]  ext_rd_addr,
  input  logic [data_width-1:0]  ext_rd_data,
  input  logic                   ext_rd_data_valid,
  output logic [tag_w+idx_w-1:0] mem_waddr,
  output logic                   mem_wen,
  output logic [data_width-1:0]  mem_wdata,
  output logic                   fill_err
);

  fill_state_e state, state_next;

  logic [tag_w-1:0] tag_q;
  logic [cnt_w-1:0] recv_cnt;
  logic [cnt_w-1:0] nwords;
  logic [idx_w-1:0] start_idx;
  logic             last_issue;
  logic             accept;
  logic             take_rsp;
  logic             stray_rsp;
  logic             last_rsp;
  logic             illegal_gnt;

  assign fetch_gnt    = (state == IDLE) && fetch_req;
  assign illegal_gnt  = fetch_gnt && !cmd_is_legal(fetch_cmd);
  assign ext_rd_valid = (state == ISSUE);
  assign fetch_done   = (state == DONE);
  assign accept       = ext_rd_valid && ext_rd_ready;
  assign take_rsp     = ext_rd_data_valid && ((state == ISSUE) || (state == WAIT));
  assign stray_rsp    = ext_rd_data_valid && !((state == ISSUE) || (state == WAIT));
  assign last_rsp     = take_rsp && (recv_cnt == nwords - 1'b1);

  fill_addr_gen #(
    .addr_width(addr_width),
    .data_width(data_width),
    .list_width(list_width)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fetch_gnt),
    .advance   (accept),
    .cmd       (fetch_cmd),
    .addr      (fetch_addr),
    .rd_addr   (ext_rd_addr),
    .nwords    (nwords),
    .start_idx (start_idx),
    .last_issue(last_issue)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A return may land in the same cycle as the final accept, so it wins over ISSUE->WAIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_gnt) state_next = cmd_is_legal(fetch_cmd) ? ISSUE : DONE;
      ISSUE: begin
        if (last_rsp)                    state_next = FLUSH;
        else if (accept && last_issue)   state_next = WAIT;
      end
      WAIT:    if (last_rsp) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write port is registered one cycle behind each accepted return; word index wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q     <= '0;
      recv_cnt  <= '0;
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      fill_err  <= 1'b0;
    end else begin
      mem_wen <= take_rsp;
      if (fetch_gnt) begin
        tag_q    <= fetch_tag;
        recv_cnt <= '0;
      end
      if (take_rsp) begin
        recv_cnt  <= recv_cnt + 1'b1;
        mem_waddr <= {tag_q, start_idx + recv_cnt[idx_w-1:0]};
        mem_wdata <= ext_rd_data;
      end
      if (illegal_gnt || stray_rsp) fill_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fill_ctrl.sv
// Self-checking bench for fill_ctrl: a randomized backing-memory responder plus a
// reference model of the expected request addresses, line-buffer writes and timing.
module tb_fill_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [1:0]  fetch_cmd = 2'b00;
  logic [1:0]  fetch_tag = 2'b00;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_gnt, fetch_done, ext_rd_valid, mem_wen, fill_err;
  logic        ext_rd_ready = 1'b0;
  logic [31:0] ext_rd_addr;
  logic [31:0] ext_rd_data = 32'h0;
  logic        ext_rd_data_valid = 1'b0;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;

  fill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_cmd(fetch_cmd), .fetch_tag(fetch_tag), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
    .ext_rd_valid(ext_rd_valid), .ext_rd_ready(ext_rd_ready), .ext_rd_addr(ext_rd_addr),
    .ext_rd_data(ext_rd_data), .ext_rd_data_valid(ext_rd_data_valid),
    .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] salt = 32'h0;
  logic        rdy_rand = 1'b0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        stray = 1'b0;
  logic        rdy;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_addr = 32'h0;
  int          hold_chk = 0;
  int          hold_viol = 0;
  int          ret_cnt = 0;
  int          last_ret_cyc = -100;
  int          done_cnt = 0;
  int          done_cyc = -100;
  logic [31:0] acc_q[$];
  logic [31:0] pend_q[$];
  int          due_q[$];
  logic [6:0]  wa_q[$];
  logic [31:0] wd_q[$];

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ salt;
  endfunction

  // Backing memory: random ready, in-order returns after a random latency.
  always begin
    @(negedge clk);
    #1;
    if (stall_prev && ext_rd_valid) begin
      hold_chk++;
      if (ext_rd_addr !== stall_addr) hold_viol++;
    end
    rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    ext_rd_ready = rdy;
    stall_prev = rst_n && ext_rd_valid && !rdy;
    stall_addr = ext_rd_addr;
    if (rst_n && ext_rd_valid && rdy) begin
      acc_q.push_back(ext_rd_addr);
      pend_q.push_back(ext_rd_addr);
      due_q.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
    end
    ext_rd_data_valid = 1'b0;
    ext_rd_data = $urandom;
    if (pend_q.size() != 0 && due_q[0] <= cyc) begin
      ext_rd_data_valid = 1'b1;
      ext_rd_data = word_of(pend_q.pop_front());
      void'(due_q.pop_front());
      ret_cnt++;
      last_ret_cyc = cyc;
    end else if (stray) begin
      ext_rd_data_valid = 1'b1;
      stray = 1'b0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (mem_wen) begin
      wa_q.push_back(mem_waddr);
      wd_q.push_back(mem_wdata);
    end
    if (fetch_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_done", 32'(fetch_done), 0);
    checkOutput("rst_rd_valid", 32'(ext_rd_valid), 0);
    checkOutput("rst_wen", 32'(mem_wen), 0);
    checkOutput("rst_err", 32'(fill_err), 0);
    checkOutput("rst_rd_addr", ext_rd_addr, 0);
    checkOutput("rst_waddr", 32'(mem_waddr), 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_gnt", 32'(fetch_gnt), 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs();
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [1:0] cmd, input logic [1:0] tag,
                               input logic [31:0] addr, output int gcyc);
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_cmd = cmd;
    fetch_tag = tag;
    fetch_addr = addr;
    #1;
    checkOutput("gnt", 32'(fetch_gnt), 1);
    gcyc = cyc;
    @(negedge clk);
    fetch_req = 1'b0;
    fetch_tag = 2'($urandom);
    fetch_addr = $urandom;
  endtask

  task automatic waitDone(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_timeout", 32'(done_cnt > d0), 1);
  endtask

  task automatic runFill(input logic [1:0] cmd, input logic [1:0] tag, input logic [31:0] addr);
    int d0, gcyc, nw, st;
    logic [31:0] base;
    acc_q.delete();
    wa_q.delete();
    wd_q.delete();
    d0 = done_cnt;
    applyStimulus(cmd, tag, addr, gcyc);
    waitDone(d0);
    repeat (3) @(negedge clk);
    if (cmd == FETCH_LINE) begin
      base = addr & 32'hFFFF_FF80;
      nw = 32;
      st = 0;
    end else begin
      base = addr & 32'hFFFF_FFFC;
      nw = 1;
      st = int'(addr[6:2]);
    end
    checkOutput("req_count", acc_q.size(), nw);
    for (int i = 0; i < nw && i < acc_q.size(); i++)
      checkOutput("req_addr", acc_q[i], base + 32'(4 * i));
    checkOutput("wr_count", wa_q.size(), nw);
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      checkOutput("wr_addr", 32'(wa_q[i]), 32'(tag) * 32 + 32'((st + i) % 32));
      checkOutput("wr_data", wd_q[i], word_of(base + 32'(4 * i)));
    end
    checkOutput("done_count", done_cnt - d0, 1);
    checkOutput("done_latency", done_cyc - last_ret_cyc, 2);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, gcyc, gcyc2, n, r0, r1;
    logic [1:0] cmd;

    doReset();

    // Full line, always ready, one-cycle latency.
    salt = $urandom;
    runFill(FETCH_LINE, 2'd2, 32'h0000_1234);

    // Single word lands at slot 1, word 13.
    runFill(FETCH_WORD, 2'd1, 32'h0000_1234);
    checkOutput("word_err", 32'(fill_err), 0);

    // Backpressure and random latency.
    rdy_rand = 1'b1;
    lat_min = 1;
    lat_max = 5;
    for (int t = 0; t < 4; t++) begin
      salt = $urandom;
      cmd = (t == 0 || t == 2) ? FETCH_LINE : FETCH_WORD;
      runFill(cmd, 2'($urandom), $urandom);
    end
    checkOutput("stall_seen", 32'(hold_chk > 0), 1);
    checkOutput("stall_addr_hold", hold_viol, 0);
    checkOutput("rand_err", 32'(fill_err), 0);

    // Request held while busy is only re-granted the cycle after fetch_done.
    rdy_rand = 1'b0;
    lat_min = 1;
    lat_max = 2;
    d0 = done_cnt;
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_cmd = FETCH_LINE;
    fetch_tag = 2'd0;
    fetch_addr = $urandom;
    #1;
    checkOutput("hold_first_gnt", 32'(fetch_gnt), 1);
    n = 0;
    gcyc2 = -1;
    while (n < 300) begin
      @(negedge clk);
      fetch_cmd = FETCH_WORD;
      #1;
      if (fetch_gnt) begin
        gcyc2 = cyc;
        break;
      end
      n++;
    end
    checkOutput("hold_done_count", done_cnt - d0, 1);
    checkOutput("hold_regrant_cycle", gcyc2 - done_cyc, 1);
    @(negedge clk);
    fetch_req = 1'b0;
    waitDone(d0 + 1);
    repeat (3) @(negedge clk);
    checkOutput("err_before_stray", 32'(fill_err), 0);
    stray = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("err_after_stray", 32'(fill_err), 1);

    // Illegal command: granted, no traffic, done next cycle, sticky error.
    doReset();
    acc_q.delete();
    wa_q.delete();
    wd_q.delete();
    d0 = done_cnt;
    applyStimulus(FETCH_RSVD, 2'd1, $urandom, gcyc);
    repeat (4) @(negedge clk);
    checkOutput("ill_req_count", acc_q.size(), 0);
    checkOutput("ill_wr_count", wa_q.size(), 0);
    checkOutput("ill_done_count", done_cnt - d0, 1);
    checkOutput("ill_done_latency", done_cyc - gcyc, 1);
    checkOutput("ill_err", 32'(fill_err), 1);

    // Reset after 10 returns of a line fill aborts it without fetch_done.
    lat_min = 3;
    lat_max = 3;
    acc_q.delete();
    wa_q.delete();
    wd_q.delete();
    d0 = done_cnt;
    applyStimulus(FETCH_LINE, 2'd3, $urandom, gcyc);
    r0 = ret_cnt;
    n = 0;
    while (ret_cnt - r0 < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_ret_wait", ret_cnt - r0, 10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkResetOutputs();
    r1 = ret_cnt;
    repeat (12) @(negedge clk);
    checkOutput("abort_wr_count", wa_q.size(), 10);
    checkOutput("abort_no_done", done_cnt - d0, 0);
    checkOutput("abort_late_err", 32'(fill_err), 32'(ret_cnt > r1));
    lat_min = 1;
    lat_max = 4;
    runFill(FETCH_WORD, 2'd0, $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fill_ctrl.md
Name: fill_ctrl

Overview:
Line-fill responder for the cache read path. Accepts fetch requests (fetch_req/fetch_cmd/fetch_tag/fetch_addr) from the read controller and grants one at a time. For each granted fetch it reads the line, or a single word, from backing memory and writes it into the line-buffer memory slot selected by fetch_tag. It pulses fetch_done once the data is visible to the line-buffer read port (mem_raddr/mem_ren).

Parameters:
addr_width, 32, byte-address width
list_depth, 4, number of line slots; tag width = $clog2(list_depth)
data_width, 32, word width in bits; byte stride per word = data_width/8
list_width, 32, words per line; word-index width = $clog2(list_width)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
fetch_req  in  1  fetch request; held until fetch_gnt
fetch_cmd  in  2  2'b01 FILL_LINE, 2'b10 FILL_WORD, 2'b00/2'b11 illegal
fetch_tag  in  $clog2(list_depth)  destination line slot
fetch_addr  in  addr_width  miss byte address
fetch_gnt  out  1  request accepted (combinational)
fetch_done  out  1  one-cycle pulse: fill complete
ext_rd_valid  out  1  backing-memory read request
ext_rd_ready  in  1  request accepted when valid&&ready
ext_rd_addr  out  addr_width  word-aligned byte address
ext_rd_data  in  data_width  return data, in order
ext_rd_data_valid  in  1  return strobe; no backpressure
mem_waddr  out  $clog2(list_depth)+$clog2(list_width)  {tag, word_index}
mem_wen  out  1  line-buffer write enable
mem_wdata  out  data_width  line-buffer write data
fill_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, counters 0. Outputs fetch_done, ext_rd_valid, mem_wen and fill_err are 0. ext_rd_addr, mem_waddr and mem_wdata are 0. fetch_gnt is 0 because it is decoded from IDLE.
- Reset mid-fill aborts the fill with no fetch_done. Responses still in flight afterwards are ignored in IDLE.
- fetch_gnt = (state==IDLE) && fetch_req. On grant, latch tag, cmd and addr.
  - FILL_LINE: base = addr with low $clog2(list_width)+$clog2(data_width/8) bits cleared. nwords = list_width. Starting word index = 0.
  - FILL_WORD: base = addr with low $clog2(data_width/8) bits cleared. nwords = 1. Word index = addr[word-index field].
- State machine:
  - IDLE -> ISSUE on a grant with a legal cmd.
  - IDLE -> DONE on a grant with an illegal cmd. This sets fill_err and generates no memory traffic.
  - ISSUE: ext_rd_valid=1. ext_rd_addr = base + issue_cnt*(data_width/8). issue_cnt increments on valid&&ready. ISSUE -> WAIT when the final request is accepted.
  - WAIT: ext_rd_valid=0. Waits for return data.
  - Returns are accepted in ISSUE and WAIT. Each ext_rd_data_valid increments recv_cnt.
  - One cycle after each return, the registered write fires: mem_wen=1, mem_wdata=ext_rd_data, mem_waddr={tag, start_idx+recv_cnt}.
  - Word index wraps modulo list_width. This never occurs with legal commands.
  - The cycle the last return is seen, the state moves to FLUSH. FLUSH is the cycle in which the last mem_wen is high.
  - FLUSH -> DONE. DONE: fetch_done=1 for exactly one cycle. DONE -> IDLE.
- Latency: last ext_rd_data_valid at cycle t gives mem_wen at t+1 and fetch_done at t+2. The next fetch_gnt can occur no earlier than t+3.
- Returns may arrive in the same cycle as the request they answer is accepted. Returns overlap further issues freely. recv_cnt never exceeds issue_cnt.
- An ext_rd_data_valid seen in IDLE, FLUSH or DONE is dropped and sets fill_err.
- Counter width is $clog2(list_width)+1, so a count of list_width is representable.
- Only one fetch is in flight at a time. fetch_req while busy receives no grant.

Decomposition:
- Package cache_pkg holds:
  - typedef fetch_cmd_e, with FETCH_NOP=2'b00, FETCH_LINE=2'b01, FETCH_WORD=2'b10, FETCH_RSVD=2'b11;
  - typedef fill_state_e, with IDLE, ISSUE, WAIT, FLUSH, DONE.
- These are shared with the read controller and the bench.
- Sub-module fill_addr_gen: computes base, nwords and start_idx from cmd and addr (combinational), and holds the issue counter and address increment.

Test Plan:
- All cases use default parameters.
- FILL_LINE, tag=2, addr=0x0000_1234, ext_rd_ready=1, read latency 1:
  - ext_rd_addr runs 0x1200,0x1204,...,0x127C (32 requests);
  - mem_waddr runs 64..95 in order with matching data;
  - exactly one fetch_done, 2 cycles after the last return.
- FILL_WORD, tag=1, addr=0x0000_1234:
  - a single ext read at 0x1234;
  - one mem_wen at mem_waddr=32+13=45;
  - fetch_done 2 cycles after the return; fill_err=0.
- FILL_LINE with ext_rd_ready toggling 1/0 and a random return latency of 1-5 cycles: 32 writes in address order, the address does not advance while ready=0, and no write is lost.
- fetch_cmd=2'b11: fetch_gnt=1, no ext_rd_valid, no mem_wen, fetch_done 1 cycle later, fill_err=1.
- rst_n=0 for 1 cycle after 10 returns of a FILL_LINE:
  - outputs return to their reset values the next cycle;
  - the 3 late returns are dropped with no mem_wen;
  - no fetch_done;
  - a new fetch_req is granted.
- fetch_req held during a busy fill: no grant until the cycle after fetch_done. A stray ext_rd_data_valid in IDLE sets fill_err.
